// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM cell-update datapath: default word geometry,
// fixed-point constants, FSM state encoding and saturating arithmetic helpers.
// The helpers operate at the package word width, so a top-level instance
// using non-default widths must be paired with matching package constants.
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;

  localparam int ONE_Q  = 1 << LSTM_FRACT_WIDTH;
  localparam int HALF_Q = ONE_Q / 2;

  localparam logic signed [LSTM_DATA_WIDTH-1:0] MAX_Q = {1'b0, {(LSTM_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [LSTM_DATA_WIDTH-1:0] MIN_Q = {1'b1, {(LSTM_DATA_WIDTH-1){1'b0}}};

  // Each working state is named after the result it produces on its exit edge.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACT  = 3'd1,
    ST_FC   = 3'd2,
    ST_IG   = 3'd3,
    ST_CUPD = 3'd4,
    ST_OH   = 3'd5,
    ST_OUT  = 3'd6
  } lstm_state_e;

  typedef enum logic {
    ACT_SIGMOID = 1'b0,
    ACT_TANH    = 1'b1
  } act_sel_e;

  // Fixed-point product: full-width multiply, floor shift back to the fraction
  // position, then clamp to the representable range.
  function automatic logic signed [LSTM_DATA_WIDTH-1:0] sat_mul(
    input logic signed [LSTM_DATA_WIDTH-1:0] a,
    input logic signed [LSTM_DATA_WIDTH-1:0] b
  );
    logic signed [2*LSTM_DATA_WIDTH-1:0] prod;
    logic signed [2*LSTM_DATA_WIDTH-1:0] shifted;
    prod    = (2*LSTM_DATA_WIDTH)'(a) * (2*LSTM_DATA_WIDTH)'(b);
    shifted = prod >>> LSTM_FRACT_WIDTH;
    if (shifted > (2*LSTM_DATA_WIDTH)'(MAX_Q)) begin
      return MAX_Q;
    end else if (shifted < (2*LSTM_DATA_WIDTH)'(MIN_Q)) begin
      return MIN_Q;
    end else begin
      return shifted[LSTM_DATA_WIDTH-1:0];
    end
  endfunction

  // Sum with one guard bit, clamped back to the word range.
  function automatic logic signed [LSTM_DATA_WIDTH-1:0] sat_add(
    input logic signed [LSTM_DATA_WIDTH-1:0] a,
    input logic signed [LSTM_DATA_WIDTH-1:0] b
  );
    logic signed [LSTM_DATA_WIDTH:0] sum;
    sum = (LSTM_DATA_WIDTH+1)'(a) + (LSTM_DATA_WIDTH+1)'(b);
    if (sum > (LSTM_DATA_WIDTH+1)'(MAX_Q)) begin
      return MAX_Q;
    end else if (sum < (LSTM_DATA_WIDTH+1)'(MIN_Q)) begin
      return MIN_Q;
    end else begin
      return sum[LSTM_DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/lstm_cell_update_act.sv
// Piecewise-linear activation: hard sigmoid (x/4 + 1/2 clamped to [0,1]) or
// hard tanh (x clamped to [-1,1]), selected by sel. Purely combinational.
module lstm_hard_act
  import lstm_pkg::*;
#(
  parameter int DW = LSTM_DATA_WIDTH,
  parameter int FW = LSTM_FRACT_WIDTH
) (
  input  logic signed [DW-1:0] x,
  input  act_sel_e             sel,
  output logic signed [DW-1:0] y
);

  localparam logic signed [DW:0]   HALF_W    = (DW+1)'(1 << (FW-1));
  localparam logic signed [DW:0]   ONE_W     = (DW+1)'(1 << FW);
  localparam logic signed [DW-1:0] ONE_D     = DW'(1 << FW);
  localparam logic signed [DW-1:0] NEG_ONE_D = -ONE_D;

  logic signed [DW:0] w_quarter;
  logic signed [DW:0] w_sigSum;

  // Sigmoid pre-clamp value, kept one bit wider so the +1/2 offset cannot wrap.
  always_comb begin
    w_quarter = (DW+1)'(x) >>> 2;
    w_sigSum  = w_quarter + HALF_W;
  end

  // Clamp into the selected function's output range.
  always_comb begin
    y = x;
    if (sel == ACT_SIGMOID) begin
      if (w_sigSum[DW]) begin
        y = '0;
      end else if (w_sigSum > ONE_W) begin
        y = ONE_D;
      end else begin
        y = w_sigSum[DW-1:0];
      end
    end else begin
      if (x > ONE_D) begin
        y = ONE_D;
      end else if (x < NEG_ONE_D) begin
        y = NEG_ONE_D;
      end else begin
        y = x;
      end
    end
  end

endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell-state and hidden-output update. Accepts the four gate
// pre-activations, activates them, then walks one shared saturating multiplier
// through f*c_prev, i*g and o*tanh(c) to produce c_t and h_t. The cell state is
// kept between transactions so it can be fed back on the next time step.
module lstm_cell_update
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH = LSTM_FRACT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         c_clear,
  input  logic signed [DATA_WIDTH-1:0] pre_i,
  input  logic signed [DATA_WIDTH-1:0] pre_f,
  input  logic signed [DATA_WIDTH-1:0] pre_g,
  input  logic signed [DATA_WIDTH-1:0] pre_o,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] h_out,
  output logic signed [DATA_WIDTH-1:0] c_out
);

  lstm_state_e r_state;
  logic        r_inReady;
  logic        r_outValid;

  logic signed [DATA_WIDTH-1:0] r_hOut;
  logic signed [DATA_WIDTH-1:0] r_cOut;
  logic signed [DATA_WIDTH-1:0] r_preI;
  logic signed [DATA_WIDTH-1:0] r_preF;
  logic signed [DATA_WIDTH-1:0] r_preG;
  logic signed [DATA_WIDTH-1:0] r_preO;
  logic signed [DATA_WIDTH-1:0] r_cPrev;
  logic signed [DATA_WIDTH-1:0] r_iAct;
  logic signed [DATA_WIDTH-1:0] r_fAct;
  logic signed [DATA_WIDTH-1:0] r_gAct;
  logic signed [DATA_WIDTH-1:0] r_oAct;
  logic signed [DATA_WIDTH-1:0] r_fc;
  logic signed [DATA_WIDTH-1:0] r_ig;
  logic signed [DATA_WIDTH-1:0] r_tanhC;

  logic signed [DATA_WIDTH-1:0] w_iAct;
  logic signed [DATA_WIDTH-1:0] w_fAct;
  logic signed [DATA_WIDTH-1:0] w_gAct;
  logic signed [DATA_WIDTH-1:0] w_oAct;
  logic signed [DATA_WIDTH-1:0] w_cSum;
  logic signed [DATA_WIDTH-1:0] w_tanhSum;
  logic signed [DATA_WIDTH-1:0] w_mulA;
  logic signed [DATA_WIDTH-1:0] w_mulB;
  logic signed [DATA_WIDTH-1:0] w_mulOut;

  lstm_hard_act #(.DW(DATA_WIDTH), .FW(FRACT_WIDTH)) u_actI (
    .x(r_preI), .sel(ACT_SIGMOID), .y(w_iAct)
  );

  lstm_hard_act #(.DW(DATA_WIDTH), .FW(FRACT_WIDTH)) u_actF (
    .x(r_preF), .sel(ACT_SIGMOID), .y(w_fAct)
  );

  lstm_hard_act #(.DW(DATA_WIDTH), .FW(FRACT_WIDTH)) u_actG (
    .x(r_preG), .sel(ACT_TANH), .y(w_gAct)
  );

  lstm_hard_act #(.DW(DATA_WIDTH), .FW(FRACT_WIDTH)) u_actO (
    .x(r_preO), .sel(ACT_SIGMOID), .y(w_oAct)
  );

  // tanh of the new cell state is taken from the unregistered sum so it can be
  // captured on the same edge as c_t itself.
  lstm_hard_act #(.DW(DATA_WIDTH), .FW(FRACT_WIDTH)) u_actC (
    .x(w_cSum), .sel(ACT_TANH), .y(w_tanhSum)
  );

  // New cell state from the two partial products.
  always_comb begin
    w_cSum = sat_add(r_fc, r_ig);
  end

  // Steer the shared multiplier's operands according to the current step.
  always_comb begin
    w_mulA = '0;
    w_mulB = '0;
    case (r_state)
      ST_FC: begin
        w_mulA = r_fAct;
        w_mulB = r_cPrev;
      end
      ST_IG: begin
        w_mulA = r_iAct;
        w_mulB = r_gAct;
      end
      ST_OH: begin
        w_mulA = r_oAct;
        w_mulB = r_tanhC;
      end
      default: begin
        w_mulA = '0;
        w_mulB = '0;
      end
    endcase
    w_mulOut = sat_mul(w_mulA, w_mulB);
  end

  // Sequencer: one datapath step per cycle, with handshake flags and results
  // held in registers so outputs never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_hOut     <= '0;
      r_cOut     <= '0;
      r_preI     <= '0;
      r_preF     <= '0;
      r_preG     <= '0;
      r_preO     <= '0;
      r_cPrev    <= '0;
      r_iAct     <= '0;
      r_fAct     <= '0;
      r_gAct     <= '0;
      r_oAct     <= '0;
      r_fc       <= '0;
      r_ig       <= '0;
      r_tanhC    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_preI    <= pre_i;
            r_preF    <= pre_f;
            r_preG    <= pre_g;
            r_preO    <= pre_o;
            r_cPrev   <= c_clear ? '0 : r_cOut;
            r_inReady <= 1'b0;
            r_state   <= ST_ACT;
          end
        end
        ST_ACT: begin
          r_iAct  <= w_iAct;
          r_fAct  <= w_fAct;
          r_gAct  <= w_gAct;
          r_oAct  <= w_oAct;
          r_state <= ST_FC;
        end
        ST_FC: begin
          r_fc    <= w_mulOut;
          r_state <= ST_IG;
        end
        ST_IG: begin
          r_ig    <= w_mulOut;
          r_state <= ST_CUPD;
        end
        ST_CUPD: begin
          r_cOut  <= w_cSum;
          r_tanhC <= w_tanhSum;
          r_state <= ST_OH;
        end
        ST_OH: begin
          r_hOut     <= w_mulOut;
          r_outValid <= 1'b1;
          r_state    <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign h_out     = r_hOut;
  assign c_out     = r_cOut;

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed bench for lstm_cell_update: reset values, exact result latency,
// recurrent cell state, sigmoid/tanh clamping, backpressure and reset abort.
module tb_lstm_cell_update;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        c_clear;
  logic [15:0] pre_i;
  logic [15:0] pre_f;
  logic [15:0] pre_g;
  logic [15:0] pre_o;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] h_out;
  logic [15:0] c_out;

  int assertCount = 0;
  int failCount   = 0;

  lstm_cell_update #(.DATA_WIDTH(16), .FRACT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_clear   (c_clear),
    .pre_i     (pre_i),
    .pre_f     (pre_f),
    .pre_g     (pre_g),
    .pre_o     (pre_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h_out     (h_out),
    .c_out     (c_out)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one transaction at a negedge, let it be accepted, then scramble the
  // inputs so the design must rely on its latched copy.
  task automatic applyStimulus(input logic cClear, input logic [15:0] i,
                               input logic [15:0] f, input logic [15:0] g,
                               input logic [15:0] o);
    @(negedge clk);
    checkOutput("in_ready_idle", {15'b0, in_ready}, 16'h0001);
    in_valid = 1'b1;
    c_clear  = cClear;
    pre_i    = i;
    pre_f    = f;
    pre_g    = g;
    pre_o    = o;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c_clear  = ~cClear;
    pre_i    = 16'($urandom);
    pre_f    = 16'($urandom);
    pre_g    = 16'($urandom);
    pre_o    = 16'($urandom);
    checkOutput("in_ready_busy", {15'b0, in_ready}, 16'h0000);
  endtask

  // c_t lands on the 4th edge after acceptance, h_t and out_valid on the 5th.
  task automatic waitResult(input string tag, input logic [15:0] expC,
                            input logic [15:0] expH);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({tag, "_c_at_e4"}, c_out, expC);
    checkOutput({tag, "_valid_e4"}, {15'b0, out_valid}, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_e5"}, {15'b0, out_valid}, 16'h0001);
    checkOutput({tag, "_c"}, c_out, expC);
    checkOutput({tag, "_h"}, h_out, expH);
  endtask

  task automatic releaseOutput(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {15'b0, out_valid}, 16'h0000);
    checkOutput({tag, "_ready_back"}, {15'b0, in_ready}, 16'h0001);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    c_clear   = 1'b0;
    out_ready = 1'b0;
    pre_i     = '0;
    pre_f     = '0;
    pre_g     = '0;
    pre_o     = '0;

    // Reset values, both while held and after release.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("post_rst_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("post_rst_h", h_out, 16'h0000);
    checkOutput("post_rst_c", c_out, 16'h0000);

    // Saturated gates, cleared state: c = 0 + 1*1, h = 1*tanh(1).
    applyStimulus(1'b1, 16'h0800, 16'h0800, 16'h0100, 16'h0800);
    waitResult("txn1", 16'h0100, 16'h0100);
    releaseOutput("txn1");

    // Same inputs, state carried: c = 1*1 + 1*1 = 2, h = tanh clamps to 1.
    applyStimulus(1'b0, 16'h0800, 16'h0800, 16'h0100, 16'h0800);
    waitResult("txn2", 16'h0200, 16'h0100);
    releaseOutput("txn2");

    // Negative candidate, half gates: c = -1, h = 0.5*-1 = -0.5.
    applyStimulus(1'b1, 16'h0800, 16'h0000, 16'hF800, 16'h0000);
    waitResult("neg", 16'hFF00, 16'hFF80);
    releaseOutput("neg");

    // All-zero pre-activations with cleared state.
    applyStimulus(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    waitResult("zero", 16'h0000, 16'h0000);
    releaseOutput("zero");

    // g = 0.5 gives c = 0.5 and h = 0.5; then stall the consumer while a new
    // request waits at the input.
    applyStimulus(1'b1, 16'h0800, 16'h0800, 16'h0080, 16'h0800);
    waitResult("bp", 16'h0080, 16'h0080);
    in_valid = 1'b1;
    c_clear  = 1'b1;
    pre_i    = 16'h0800;
    pre_f    = 16'h0800;
    pre_g    = 16'h0100;
    pre_o    = 16'h0800;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", {15'b0, out_valid}, 16'h0001);
      checkOutput("bp_hold_h", h_out, 16'h0080);
      checkOutput("bp_hold_c", c_out, 16'h0080);
      checkOutput("bp_hold_in_ready", {15'b0, in_ready}, 16'h0000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("bp_release_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("bp_release_no_accept", {15'b0, in_ready}, 16'h0001);
    checkOutput("bp_release_c", c_out, 16'h0080);

    // Sigmoid clamps low: i and o gates shut, forget passes c = 0.5 through.
    applyStimulus(1'b0, 16'hF000, 16'h0800, 16'h0100, 16'hF000);
    waitResult("clamp_lo", 16'h0080, 16'h0000);
    releaseOutput("clamp_lo");

    // Mid-range sigmoid: sig(1.0) = 0.75, so c = 0.75*0.5 = 0.375 and
    // h = 0.75*0.375 = 0.28125.
    applyStimulus(1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0100);
    waitResult("mid", 16'h0060, 16'h0048);
    releaseOutput("mid");

    // Abort a transaction while the forget product is being formed.
    applyStimulus(1'b0, 16'h0800, 16'h0800, 16'h0100, 16'h0800);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", {15'b0, in_ready}, 16'h0001);
    checkOutput("midrst_out_valid", {15'b0, out_valid}, 16'h0000);
    checkOutput("midrst_h", h_out, 16'h0000);
    checkOutput("midrst_c", c_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midrst_no_result", {15'b0, out_valid}, 16'h0000);
    checkOutput("midrst_c_kept", c_out, 16'h0000);

    // Carried state is now zero, so this matches the cleared first step.
    applyStimulus(1'b0, 16'h0800, 16'h0800, 16'h0100, 16'h0800);
    waitResult("after_rst", 16'h0100, 16'h0100);
    releaseOutput("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
